btn_debounce: RTL and testbench
===============================

# btn_debounce

Input-conditioning stage that sits directly upstream of the LFSR/seven-segment display top. It turns the raw, bouncy push-button into clean events: a synchronized debounced level, one-cycle press/release pulses, and a `step` pulse (press plus optional auto-repeat) that drives the LFSR shift enable. The LFSR advances once per physical press, or at a controlled rate while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 16, stable cycles required to accept a level change; must be at least 1.
- `CNT_W`, default 24, width of both internal counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- `REPEAT_EN`, default 0, 1 enables auto-repeat on `step`.
- `REPEAT_DELAY`, default 8, cycles from press to the first repeat `step`; must be at least 1.
- `REPEAT_PERIOD`, default 4, cycles between subsequent repeat `step`s; must be at least 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `btn`  in  1  raw button, asynchronous to `clk`, active-high.
- `btn_level`  out  1  debounced level.
- `press`  out  1  one-cycle pulse on an accepted press.
- `release`  out  1  one-cycle pulse on an accepted release.
- `step`  out  1  one-cycle pulse; `press` OR repeat tick. This output feeds the LFSR enable.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`. Both reset to 0. The FSM uses only `s2`.
- **FSM states:** IDLE (stable released), ARM (candidate press), HELD (stable pressed), DISARM (candidate release).
  - IDLE: if `s2`=1, go to ARM and set cnt=0.
  - ARM: if `s2`=0, return to IDLE with no pulse. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to HELD and pulse `press` and `step`; else cnt++.
  - HELD: if `s2`=0, go to DISARM and set cnt=0.
  - DISARM: if `s2`=1, return to HELD with no pulse; the repeat counter resumes. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE and pulse `release`; else cnt++.
- **`btn_level`:** 1 in HELD and DISARM; 0 in IDLE and ARM. It changes on the same edge as the `press`/`release` pulse.
- **Repeat counter `rcnt`:**
  - Cleared on the ARM→HELD transition.
  - Counts in HELD.
  - Frozen in DISARM.
  - Cleared in IDLE and ARM.
  - A repeat tick fires when `rcnt` reaches REPEAT_DELAY-1 (first tick) and then every REPEAT_PERIOD cycles after that. A phase flag selects the active limit.
- With REPEAT_EN=0, `step` is identical to `press`.
- All outputs are registered, with no combinational path from `btn`.

## Timing
- **Reset:** asynchronous assertion. `s1`, `s2`, `btn_level`, `press`, `release` and `step` all go to 0; state goes to IDLE; cnt, `rcnt` and the phase flag go to 0. Deassertion is synchronous to `clk`.
- **Press latency:** let edge 0 be the first edge that samples `btn`=1 into `s1`. ARM is entered at edge 2. `press` is high for exactly the one cycle following edge 2+DEBOUNCE_CYCLES.
- **Release latency:** symmetric with press latency, measured from the falling input.
- **Bounce shorter than DEBOUNCE_CYCLES:** no pulse and no level change. Each bounce restarts the count from 0.
- **Repeat ticks:** after a press at edge P, repeat `step`s follow edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on. Each cycle spent in DISARM delays the schedule by one.
- **Simultaneous events:**
  - `press` and a repeat tick never coincide.
  - `release` cannot coincide with `step`, because `rcnt` is frozen in DISARM.
- **Reset mid-press:** pulses are aborted. If `btn` is still high after reset, it is treated as a new press and needs the full latency.
- **Counters:** never wrap, because the limits are below 2^CNT_W.

## Structure
- **Package `btn_pkg`** holds:
  - `btn_state_e` (IDLE, ARM, HELD, DISARM), 2-bit encoding.
  - Default parameter constants.
- **Sub-module `sync2`** (2-flop synchronizer with async active-low reset to 0) is the natural split, so it can be reused for any other asynchronous input in the design.
- Everything else is a single module: FSM, debounce counter, repeat counter, output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- **Clean press:** `btn` goes 0→1 and is held 20 cycles -> exactly one `press`/`step` pulse, in the cycle after edge 6; `btn_level`=1 from that cycle; no `release`.
- **Bounce:** `btn` toggles 1,0,1,0 (2 cycles each), then is held at 1 -> a single `press` 6 cycles after the final rising sample; no glitch on `btn_level`.
- **Release with bounce:** from HELD, `btn` shows a 2-cycle 0 glitch, then 0 is held -> no `release` for the glitch; one `release` 6 cycles after the stable 0 begins; `btn_level` falls with it.
- **Auto-repeat:** REPEAT_EN=1, press held 30 cycles -> `step` pulses at P, P+10, P+13, P+16, P+19, P+22, P+25, P+28; `press` only at P.
- **Reset mid-operation:** `rst` is asserted during ARM and again during HELD -> all outputs 0 immediately. With `btn` still high after release of reset, a new `press` follows edge 6 after reset release.
- **REPEAT_EN=0 long hold:** `btn` held 100 cycles -> exactly one `step`; an attached 8-bit LFSR model advances from 0x01 to 0x80.

Source files
------------

// File: rtl/btn_pkg.sv
// Purpose : shared types and default parameters for the push-button conditioning block.
// Latency : n/a (package only).
// Backpressure: n/a; button events are fire-and-forget pulses.
package btn_pkg;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // stable released
    ST_ARM    = 2'd1,  // candidate press, qualifying
    ST_HELD   = 2'd2,  // stable pressed
    ST_DISARM = 2'd3   // candidate release, qualifying
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_CNT_W           = 24;
  localparam int unsigned DEF_REPEAT_EN       = 0;
  localparam int unsigned DEF_REPEAT_DELAY    = 8;
  localparam int unsigned DEF_REPEAT_PERIOD   = 4;

endpackage

// File: rtl/btn_debounce_sync2.sv
// Purpose : two-flop synchronizer for an asynchronous single-bit input.
// Latency : 2 clk_i edges from input change to q_o.
// Backpressure: none; samples every cycle.
// Ports   : clk_i clock, rst_ni async active-low reset (flops clear to 0),
//           d_i asynchronous input, q_o synchronized output.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// Purpose : debounce a raw push-button into a clean level, press/release pulses and a step pulse with optional auto-repeat.
// Latency : press/release pulse follows edge 2+DEBOUNCE_CYCLES after the first edge sampling the new input level.
// Backpressure: none; all outputs are single-cycle registered pulses or levels.
// Ports   : clk_i clock, rst_ni async active-low reset, btn_i raw button (async, active-high),
//           btn_level_o debounced level, press_o/release_o one-cycle event pulses,
//           step_o press OR repeat tick (drives the LFSR shift enable).
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic             REP_ON      = (REPEAT_EN != 0);

  logic             btn_s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             phase_q;   // 0: waiting for first repeat, 1: periodic repeats
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             step_q;
  logic             rep_hit;

  sync2 u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_i),
    .q_o    (btn_s)
  );

  // Phase flag picks which limit ends the current repeat interval.
  assign rep_hit = phase_q ? (rcnt_q == PERIOD_LAST) : (rcnt_q == DELAY_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      phase_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rcnt_q  <= '0;
          phase_q <= 1'b0;
          if (btn_s) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
          end
        end
        ST_ARM: begin
          // rcnt is held at zero here, which also gives the clear on entry to HELD.
          rcnt_q  <= '0;
          phase_q <= 1'b0;
          if (!btn_s) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_HELD;
            level_q <= 1'b1;
            press_q <= 1'b1;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!btn_s) begin
            state_q <= ST_DISARM;
            cnt_q   <= '0;
          end
          // The repeat schedule advances on every edge spent in HELD, so only
          // DISARM cycles push it back.
          if (rep_hit) begin
            rcnt_q  <= '0;
            phase_q <= 1'b1;
            step_q  <= REP_ON;
          end else begin
            rcnt_q <= rcnt_q + CNT_W'(1);
          end
        end
        ST_DISARM: begin
          // rcnt/phase frozen so a bounce on release resumes the schedule.
          if (btn_s) begin
            state_q <= ST_HELD;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= ST_IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign btn_level_o = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign step_o      = step_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Purpose : directed bench for btn_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Latency : n/a.
// Backpressure: n/a; dut0 has repeat disabled, dut1 enabled, both share stimulus.
module tb_btn_debounce;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic btn_i = 1'b0;
  logic lvl0, prs0, rel0, stp0;
  logic lvl1, prs1, rel1, stp1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  btn_debounce #(
    .DEBOUNCE_CYCLES(4), .CNT_W(8), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i),
    .btn_level_o(lvl0), .press_o(prs0), .release_o(rel0), .step_o(stp0)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(4), .CNT_W(8), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i),
    .btn_level_o(lvl1), .press_o(prs1), .release_o(rel1), .step_o(stp1)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go_idle();
    btn_i = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    btn_i  = 1'b0;
    repeat (3) cyc();
    n_cmp++; if ({lvl0, prs0, rel0, stp0} !== 4'b0000) begin n_err++; $display("FAIL reset_dut0: got %b expected 0000", {lvl0, prs0, rel0, stp0}); end
    n_cmp++; if ({lvl1, prs1, rel1, stp1} !== 4'b0000) begin n_err++; $display("FAIL reset_dut1: got %b expected 0000", {lvl1, prs1, rel1, stp1}); end
    #4 rst_ni = 1'b1;
    repeat (3) cyc();
    n_cmp++; if ({lvl0, prs0, rel0, stp0} !== 4'b0000) begin n_err++; $display("FAIL idle_after_reset: got %b expected 0000", {lvl0, prs0, rel0, stp0}); end
  endtask

  task automatic test_clean_press();
    int np, ns, nr, pe;
    logic l5, l6;
    np = 0; ns = 0; nr = 0; pe = -1; l5 = 1'bx; l6 = 1'bx;
    btn_i = 1'b1;
    for (int e = 0; e < 20; e++) begin
      cyc();
      if (prs0) begin np++; pe = e; end
      if (stp0) ns++;
      if (rel0) nr++;
      if (e == 5) l5 = lvl0;
      if (e == 6) l6 = lvl0;
    end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL clean_press_count: got %0d expected 1", np); end
    n_cmp++; if (pe !== 6) begin n_err++; $display("FAIL clean_press_edge: got %0d expected 6", pe); end
    n_cmp++; if (ns !== 1) begin n_err++; $display("FAIL clean_step_count: got %0d expected 1", ns); end
    n_cmp++; if (nr !== 0) begin n_err++; $display("FAIL clean_no_release: got %0d expected 0", nr); end
    n_cmp++; if (l5 !== 1'b0) begin n_err++; $display("FAIL clean_level_before: got %b expected 0", l5); end
    n_cmp++; if (l6 !== 1'b1) begin n_err++; $display("FAIL clean_level_after: got %b expected 1", l6); end
  endtask

  task automatic test_release_bounce();
    logic [4:0] glitch;
    int bad, nr, re;
    logic l5, l6;
    glitch = 5'b11100;  // bit e drives edge e: 0,0,1,1,1
    bad = 0; nr = 0; re = -1; l5 = 1'bx; l6 = 1'bx;
    for (int e = 0; e < 5; e++) begin
      btn_i = glitch[e];
      cyc();
      if (rel0 || !lvl0 || stp0) bad++;
    end
    btn_i = 1'b0;
    for (int e = 0; e < 12; e++) begin
      cyc();
      if (rel0) begin nr++; re = e; end
      if (e == 5) l5 = lvl0;
      if (e == 6) l6 = lvl0;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL release_glitch_ignored: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (nr !== 1) begin n_err++; $display("FAIL release_count: got %0d expected 1", nr); end
    n_cmp++; if (re !== 6) begin n_err++; $display("FAIL release_edge: got %0d expected 6", re); end
    n_cmp++; if (l5 !== 1'b1) begin n_err++; $display("FAIL release_level_before: got %b expected 1", l5); end
    n_cmp++; if (l6 !== 1'b0) begin n_err++; $display("FAIL release_level_after: got %b expected 0", l6); end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int bad, np, pe;
    pat = 8'b00110011;  // bit e drives edge e: 1,1,0,0,1,1,0,0
    bad = 0; np = 0; pe = -1;
    for (int e = 0; e < 8; e++) begin
      btn_i = pat[e];
      cyc();
      if (prs0 || lvl0 || stp0) bad++;
    end
    btn_i = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cyc();
      if (prs0) begin np++; pe = e; end
      if (e < 6 && lvl0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bounce_no_glitch: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL bounce_press_count: got %0d expected 1", np); end
    n_cmp++; if (pe !== 6) begin n_err++; $display("FAIL bounce_press_edge: got %0d expected 6", pe); end
  endtask

  task automatic test_autorepeat();
    int exp_e[8];
    int obs[16];
    int n, np, nr, ns0;
    exp_e = '{6, 16, 19, 22, 25, 28, 31, 34};
    for (int i = 0; i < 16; i++) obs[i] = -1;
    n = 0; np = 0; nr = 0; ns0 = 0;
    btn_i = 1'b1;
    for (int e = 0; e < 37; e++) begin
      cyc();
      if (stp1) begin
        if (n < 16) obs[n] = e;
        n++;
      end
      if (prs1) np++;
      if (rel1) nr++;
      if (stp0) ns0++;
    end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL repeat_step_count: got %0d expected 8", n); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (obs[i] !== exp_e[i]) begin n_err++; $display("FAIL repeat_step_edge[%0d]: got %0d expected %0d", i, obs[i], exp_e[i]); end
    end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL repeat_press_count: got %0d expected 1", np); end
    n_cmp++; if (nr !== 0) begin n_err++; $display("FAIL repeat_no_release: got %0d expected 0", nr); end
    n_cmp++; if (ns0 !== 1) begin n_err++; $display("FAIL norepeat_step_count: got %0d expected 1", ns0); end
  endtask

  task automatic test_reset_mid();
    int pe;
    btn_i = 1'b1;
    repeat (3) cyc();  // edge 2: dut now in ARM
    rst_ni = 1'b0;
    #2;
    n_cmp++; if ({lvl0, prs0, stp0} !== 3'b000) begin n_err++; $display("FAIL rst_arm_outputs: got %b expected 000", {lvl0, prs0, stp0}); end
    #2 rst_ni = 1'b1;
    pe = -1;
    for (int e = 0; e < 7; e++) begin
      cyc();
      if (prs0) pe = e;
    end
    n_cmp++; if (pe !== 6) begin n_err++; $display("FAIL rst_arm_repress_edge: got %0d expected 6", pe); end
    // Press pulse and level are high right now; reset must drop them at once.
    rst_ni = 1'b0;
    #2;
    n_cmp++; if ({lvl0, prs0, stp0, lvl1, stp1} !== 5'b00000) begin n_err++; $display("FAIL rst_held_outputs: got %b expected 00000", {lvl0, prs0, stp0, lvl1, stp1}); end
    #2 rst_ni = 1'b1;
    pe = -1;
    for (int e = 0; e < 10; e++) begin
      cyc();
      if (prs0) pe = e;
    end
    n_cmp++; if (pe !== 6) begin n_err++; $display("FAIL rst_held_repress_edge: got %0d expected 6", pe); end
    n_cmp++; if (lvl0 !== 1'b1) begin n_err++; $display("FAIL rst_held_level: got %b expected 1", lvl0); end
  endtask

  task automatic test_long_hold();
    logic [7:0] lfsr;
    int ns0, ns1, np;
    lfsr = 8'h01; ns0 = 0; ns1 = 0; np = 0;
    btn_i = 1'b1;
    for (int e = 0; e < 100; e++) begin
      cyc();
      if (stp0) begin
        ns0++;
        // 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting toward bit 0.
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
      end
      if (stp1) ns1++;
      if (prs0) np++;
    end
    n_cmp++; if (ns0 !== 1) begin n_err++; $display("FAIL long_step_count: got %0d expected 1", ns0); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL long_press_count: got %0d expected 1", np); end
    n_cmp++; if (lfsr !== 8'h80) begin n_err++; $display("FAIL long_lfsr: got %h expected 80", lfsr); end
    n_cmp++; if (ns1 !== 29) begin n_err++; $display("FAIL long_repeat_steps: got %0d expected 29", ns1); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_bounce();
    go_idle();
    test_autorepeat();
    go_idle();
    test_reset_mid();
    go_idle();
    test_long_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
